eq_band_scaler: RTL



---
 rtl/eq_pkg.sv | 65 ++++++
 rtl/eq_csr_bank.sv | 83 ++++++++
 rtl/eq_band_scaler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared constants and arithmetic helpers for the spectral band equalizer:
// default band edges and the saturating power-of-two shift.
package eq_pkg;

    localparam int MAX_DW       = 32;
    localparam int GAIN_W_DEF   = 5;
    localparam int UNITY_DEF    = 13;
    localparam int EXP_W_DEF    = GAIN_W_DEF + 2;
    localparam int DEFAULT_SPAN = 4096;

    // Twelve-band layout is hand-tuned; any other band count gets linear spacing.
    function automatic int default_edge(input int k, input int nbands);
        if (nbands == 12) begin
            case (k)
                0:       return 6;
                1:       return 13;
                2:       return 28;
                3:       return 46;
                4:       return 82;
                5:       return 117;
                6:       return 186;
                7:       return 464;
                8:       return 929;
                9:       return 1486;
                10:      return 2601;
                default: return 3715;
            endcase
        end
        return ((k + 1) * DEFAULT_SPAN) / nbands;
    endfunction

    // e > 0 attenuates by arithmetic right shift, e < 0 boosts with saturation to dw bits.
    function automatic logic signed [MAX_DW-1:0] sat_shift(
        input logic signed [MAX_DW-1:0] sample,
        input int                       e,
        input int                       dw
    );
        logic signed [2*MAX_DW-1:0] wide;
        logic signed [2*MAX_DW-1:0] hi;
        logic signed [2*MAX_DW-1:0] lo;
        int sh;
        if (e == 0) begin
            return sample;
        end
        if (e > 0) begin
            if (e >= dw - 1) begin
                return '0;
            end
            return sample >>> e;
        end
        sh   = (-e > MAX_DW) ? MAX_DW : -e;
        wide = {{MAX_DW{sample[MAX_DW-1]}}, sample};
        wide = wide <<< sh;
        hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (dw - 1));
        if (wide > hi) begin
            return hi[MAX_DW-1:0];
        end
        if (wide < lo) begin
            return lo[MAX_DW-1:0];
        end
        return wide[MAX_DW-1:0];
    endfunction

endpackage

// File: rtl/eq_csr_bank.sv
// CSR shadow/active register sets for the equalizer: gains and band edges.
// The active set only changes on a start-of-frame load so a frame never mixes settings.
module eq_csr_bank
    import eq_pkg::*;
#(
    parameter int NBANDS = 12,
    parameter int BIN_W  = 14,
    parameter int GAIN_W = 5,
    parameter int UNITY  = 13,
    parameter int AW     = 5
) (
    input  logic                      system_clk,
    input  logic                      reset,
    input  logic [AW-1:0]             address,
    input  logic [15:0]               writedata,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    output logic [15:0]               readdata,
    input  logic                      load,
    output logic [NBANDS*GAIN_W-1:0]  active_gains,
    output logic [NBANDS*BIN_W-1:0]   active_edges
);

    logic [GAIN_W-1:0] shadow_gain [NBANDS];
    logic [GAIN_W-1:0] active_gain [NBANDS];
    logic [BIN_W-1:0]  shadow_edge [NBANDS];
    logic [BIN_W-1:0]  active_edge [NBANDS];

    logic do_write;
    logic do_read;
    logic unused_bits;

    assign do_write    = chipselect && write;
    assign do_read     = chipselect && read && !write;
    assign unused_bits = ^writedata[15:BIN_W];

    always_ff @(posedge system_clk) begin
        if (reset) begin
            for (int k = 0; k < NBANDS; k++) begin
                shadow_gain[k] <= GAIN_W'(UNITY);
                active_gain[k] <= GAIN_W'(UNITY);
                shadow_edge[k] <= BIN_W'(default_edge(k, NBANDS));
                active_edge[k] <= BIN_W'(default_edge(k, NBANDS));
            end
            readdata <= '0;
        end else begin
            if (do_write) begin
                for (int k = 0; k < NBANDS; k++) begin
                    if (int'(address) == k) begin
                        shadow_gain[k] <= writedata[GAIN_W-1:0];
                    end
                    if (int'(address) == NBANDS + k) begin
                        shadow_edge[k] <= writedata[BIN_W-1:0];
                    end
                end
            end
            if (load) begin
                for (int k = 0; k < NBANDS; k++) begin
                    active_gain[k] <= shadow_gain[k];
                    active_edge[k] <= shadow_edge[k];
                end
            end
            readdata <= '0;
            if (do_read) begin
                for (int k = 0; k < NBANDS; k++) begin
                    if (int'(address) == k) begin
                        readdata <= 16'(shadow_gain[k]);
                    end
                    if (int'(address) == NBANDS + k) begin
                        readdata <= 16'(shadow_edge[k]);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NBANDS; k++) begin : g_flat
        assign active_gains[k*GAIN_W +: GAIN_W] = active_gain[k];
        assign active_edges[k*BIN_W +: BIN_W]   = active_edge[k];
    end

endmodule

// File: rtl/eq_band_scaler.sv
// Streaming spectral equalizer: per-band power-of-two scaling of FFT bins, 2-stage pipeline.
// Define EQ_MIRROR_EN to fold upper-half bins onto their positive-frequency twins.
module eq_band_scaler
    import eq_pkg::*;
#(
    parameter int DW     = 16,
    parameter int NBANDS = 12,
    parameter int BIN_W  = 14,
    parameter int GAIN_W = 5,
    parameter int UNITY  = 13,
    parameter int AW     = 5,
    parameter int FFT_N  = 4096
) (
    input  logic          system_clk,
    input  logic          reset,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_sop,
    output logic          out_eop,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [AW-1:0] address,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read
);

    if ((1 << AW) < 2 * NBANDS) begin : g_bad_aw
        $error("eq_band_scaler: AW too small for the CSR map");
    end
    if (FFT_N > (1 << BIN_W)) begin : g_bad_fft_n
        $error("eq_band_scaler: FFT_N does not fit in BIN_W");
    end

    // Valid/ready: a beat moves on a clock edge where valid && ready; the producer
    // holds its beat stable while valid && !ready, and ready never depends on valid.
    logic adv;
    logic accept;
    logic s1_valid;
    logic s2_valid;

    logic [DW-1:0]    s1_real;
    logic [DW-1:0]    s1_imag;
    logic             s1_sop;
    logic             s1_eop;
    logic [BIN_W-1:0] s1_bin;
    logic [BIN_W-1:0] bin_cnt;
    logic [BIN_W-1:0] next_bin;

    logic [NBANDS*GAIN_W-1:0] active_gains;
    logic [NBANDS*BIN_W-1:0]  active_edges;

    logic [BIN_W-1:0]         sel_idx;
    logic [GAIN_W-1:0]        sel_gain;
    logic                     hit;
    logic signed [GAIN_W+1:0] e;
    int                       e_int;
    logic signed [MAX_DW-1:0] scaled_real;
    logic signed [MAX_DW-1:0] scaled_imag;

    assign adv       = !s2_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = s2_valid;
    assign next_bin  = in_sop ? '0 :
                       (bin_cnt == {BIN_W{1'b1}}) ? bin_cnt : bin_cnt + 1'b1;

    eq_csr_bank #(
        .NBANDS (NBANDS),
        .BIN_W  (BIN_W),
        .GAIN_W (GAIN_W),
        .UNITY  (UNITY),
        .AW     (AW)
    ) u_csr (
        .system_clk   (system_clk),
        .reset        (reset),
        .address      (address),
        .writedata    (writedata),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .readdata     (readdata),
        .load         (accept && in_sop),
        .active_gains (active_gains),
        .active_edges (active_edges)
    );

    // The active set updates on the same edge the sop beat enters stage 1,
    // so band selection on the stage-1 contents always sees that frame's settings.
    always_comb begin
`ifdef EQ_MIRROR_EN
        if (int'(s1_bin) >= FFT_N / 2) begin
            sel_idx = BIN_W'(FFT_N - int'(s1_bin));
        end else begin
            sel_idx = s1_bin;
        end
`else
        sel_idx = s1_bin;
`endif
        sel_gain = GAIN_W'(UNITY);
        hit      = 1'b0;
        for (int k = NBANDS - 1; k >= 0; k--) begin
            if (sel_idx < active_edges[k*BIN_W +: BIN_W]) begin
                sel_gain = active_gains[k*GAIN_W +: GAIN_W];
                hit      = 1'b1;
            end
        end
        e           = signed'((GAIN_W+2)'(UNITY)) - signed'({2'b00, sel_gain});
        e_int       = hit ? int'(e) : 0;
        scaled_real = sat_shift(MAX_DW'(signed'(s1_real)), e_int, DW);
        scaled_imag = sat_shift(MAX_DW'(signed'(s1_imag)), e_int, DW);
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            bin_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_real  <= '0;
            s1_imag  <= '0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_bin   <= '0;
            s2_valid <= 1'b0;
            out_real <= '0;
            out_imag <= '0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
        end else begin
            if (accept) begin
                bin_cnt <= next_bin;
            end
            if (adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_real <= in_real;
                    s1_imag <= in_imag;
                    s1_sop  <= in_sop;
                    s1_eop  <= in_eop;
                    s1_bin  <= next_bin;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_real <= scaled_real[DW-1:0];
                    out_imag <= scaled_imag[DW-1:0];
                    out_sop  <= s1_sop;
                    out_eop  <= s1_eop;
                end
            end
        end
    end

endmodule
